// File: rtl/fifo_word_serializer_pkg.sv
// rtl/fifo_word_serializer_pkg.sv - shared state encoding and defaults for the FIFO word serializer
package fifo_word_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    localparam int DEFAULT_OUT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_LOAD  = ST_LOAD,
        S_SEND  = ST_SEND
    } state_t;

    // Slice counter width; a single-slice word still needs a 1-bit counter.
    function automatic int slice_bits(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// rtl/fifo_word_serializer_if.sv - FIFO read side plus narrow output stream bundle
interface fifo_word_serializer_if
    import fifo_word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  read_enable;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;

    // The serializer drives the pop strobe and the output stream.
    modport master (
        input  fifo_empty,
        input  fifo_q,
        input  out_ready,
        output read_enable,
        output out_data,
        output out_valid,
        output out_last,
        output busy
    );

    // The FIFO and the downstream link logic.
    modport slave (
        output fifo_empty,
        output fifo_q,
        output out_ready,
        input  read_enable,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy
    );

endinterface

// File: rtl/fifo_word_serializer_word_slicer.sv
// rtl/fifo_word_serializer_word_slicer.sv - shift register and slice counter for one FIFO word
module word_slicer
    import fifo_word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
    parameter int SLICES     = DATA_WIDTH / OUT_WIDTH,
    parameter int SLICE_BITS = slice_bits(SLICES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [OUT_WIDTH-1:0]  slice,
    output logic                  last
);

    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [SLICE_BITS-1:0] cnt;

    // With a single slice the whole word leaves in one beat, so the shifted value is simply empty.
    generate
        if (SLICES == 1) begin : g_single
            assign shift_next = '0;
        end else begin : g_multi
            assign shift_next = {{OUT_WIDTH{1'b0}}, shift[DATA_WIDTH-1:OUT_WIDTH]};
        end
    endgenerate

    // Load a fresh word, or drop the accepted slice and count it.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift <= '0;
            cnt   <= '0;
        end else if (load) begin
            shift <= word;
            cnt   <= '0;
        end else if (advance) begin
            shift <= shift_next;
            cnt   <= cnt + SLICE_BITS'(1);
        end
    end

    assign slice = shift[OUT_WIDTH-1:0];
    assign last  = (cnt == SLICE_BITS'(SLICES - 1));

endmodule

// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops FIFO words and streams them out LS slice first
module fifo_word_serializer
    import fifo_word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
    parameter int SLICES     = DATA_WIDTH / OUT_WIDTH,
    parameter int SLICE_BITS = slice_bits(SLICES)
) (
    input  logic                   clock,
    input  logic                   reset,
    fifo_word_serializer_if.master bus
);

    state_t state;
    logic   read_enable_q;
    logic   out_valid_q;
    logic   busy_q;
    logic   slice_last;
    logic   accept;
    logic   load;

    assign accept = out_valid_q && bus.out_ready;
    assign load   = (state == S_LOAD);

    // Control FSM; the strobes are updated together with the state so every output comes from a flop.
    // fifo_empty is only looked at in IDLE and when the final slice leaves, so a pop never hits an empty FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            read_enable_q <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.fifo_empty) begin
                        state         <= S_FETCH;
                        read_enable_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state         <= S_LOAD;
                    read_enable_q <= 1'b0;
                end
                S_LOAD: begin
                    state       <= S_SEND;
                    out_valid_q <= 1'b1;
                end
                S_SEND: begin
                    if (accept && slice_last) begin
                        out_valid_q <= 1'b0;
                        if (!bus.fifo_empty) begin
                            state         <= S_FETCH;
                            read_enable_q <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    word_slicer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SLICES     (SLICES),
        .SLICE_BITS (SLICE_BITS)
    ) u_slicer (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (accept),
        .word    (bus.fifo_q),
        .slice   (bus.out_data),
        .last    (slice_last)
    );

    assign bus.read_enable = read_enable_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    // The counter sits at zero while idle, which would read as "last" for one-slice words.
    assign bus.out_last    = out_valid_q && slice_last;

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

- Read-side consumer placed directly downstream of the team's FIFO.
- Pops `DATA_WIDTH`-bit words with `read_enable`, honouring the FIFO's one-cycle registered `q` latency.
- Emits each word as `OUT_WIDTH`-bit slices, least-significant slice first, on a valid/ready stream toward the narrow link logic.
- Never reads an empty FIFO; holds output stable under backpressure.

## Interface

Parameters:
- `DATA_WIDTH`, 32: FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 8: output slice width.
- `SLICES`, 4: `DATA_WIDTH/OUT_WIDTH`; must be ≥1.
- `SLICE_BITS`, 2: slice counter width, `max(1, clog2(SLICES))`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  single clock; the FIFO read side uses the same clock.
- `reset`  in  1  synchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  DATA_WIDTH  FIFO read data; valid the cycle after `read_enable`.
- `read_enable`  out  1  FIFO pop strobe.
- `out_data`  out  OUT_WIDTH  current slice.
- `out_valid`  out  1  slice available.
- `out_ready`  in  1  sink accepts slice.
- `out_last`  out  1  current slice is the final slice of its word.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

States and transitions:
- IDLE
  - If `fifo_empty` = 0 at the edge, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH
  - `read_enable` = 1 for exactly this one cycle (decoded from the state register).
  - Always go to LOAD.
- LOAD
  - Capture `fifo_q` into the shift register and clear the slice counter.
  - Always go to SEND.
- SEND
  - `out_valid` = 1; `out_data` = `shift[OUT_WIDTH-1:0]`.
  - `out_last` = (`cnt` == `SLICES`-1).
  - On each edge with `out_valid && out_ready`: shift right by `OUT_WIDTH` (zero-fill) and increment `cnt`.
  - When the last slice is accepted: go to FETCH if `fifo_empty` = 0, else go to IDLE.

Stream rules:
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_last` and `out_valid` hold stable. No retraction.
- `fifo_empty` is sampled only in IDLE and at last-slice acceptance, so `read_enable` is never asserted while the FIFO is empty.
- `SLICES` = 1: `out_last` is 1 throughout SEND.

Reset:
- All outputs and internal state reset to 0 / IDLE: `read_enable`, `out_valid`, `out_last`, `busy` = 0; `out_data`, shift register and counter = 0.
- Reset mid-operation discards the partial word.
- If reset coincides with FETCH, the popped word is lost. This is acceptable because the FIFO shares the reset net and clears its pointers too.

## Timing

- `fifo_empty` falls in cycle N (state IDLE):
  - `read_enable` high in N+1.
  - Word captured at the end of N+2.
  - `out_valid` high in N+3 with slice 0.
- Latency is 3 cycles from non-empty to first slice.
- Back-to-back words with `out_ready` held at 1: `SLICES` + 2 cycles per word, i.e. two bubble cycles (FETCH, LOAD) between the last slice of one word and the first slice of the next.
- `out_ready` is a pure input; no combinational path from `out_ready` to `out_valid`.

## Structure

- Shared package holds:
  - state encoding localparams: `ST_IDLE`=2'd0, `ST_FETCH`=2'd1, `ST_LOAD`=2'd2, `ST_SEND`=2'd3;
  - the default `OUT_WIDTH`.
- One sub-module is natural: `word_slicer`, holding the shift register, `cnt` and `out_last` generation, with load/advance inputs. The FSM stays in the top module.

## Test plan

- **Single word:** reset, then one FIFO word 32'hDDCCBBAA with `out_ready`=1 → `read_enable` pulses once; `out_data` = AA, BB, CC, DD on 4 consecutive cycles; `out_last` only on DD; return to IDLE, `busy`=0.
- **Backpressure:** same word with `out_ready` = 0 for 5 cycles during slice BB → BB, `out_valid` and `out_last`=0 held for all 5 cycles; then CC, DD follow in order.
- **Back-to-back:** two words 32'h03020100 and 32'h07060504 preloaded → slices 00..07 in order; exactly 2 idle cycles between 03 and 04; exactly 2 `read_enable` pulses total.
- **Empty guard:** FIFO stays empty for 20 cycles → `read_enable`, `out_valid` and `busy` remain 0. After the last slice with the FIFO empty → no extra `read_enable` pulse.
- **Reset mid-word:** reset asserted after slice BB is accepted → next cycle all outputs 0 and state IDLE. A following word 32'h44332211 streams 11, 22, 33, 44 with no stale data.
- **SLICES=1 configuration:** `OUT_WIDTH`=32 → each word appears as one beat with `out_last`=1.
